// File: rtl/jt12_single_acc.sv
// Saturating signed frame accumulator: sums qualified inputs, publishes the total on snd at each zero edge.
// One-cycle registered update; no backpressure, clk_en gates all state.
module jt12_single_acc #(
  parameter int win  = 14,
  parameter int wout = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clk_en,
  input  logic signed [win-1:0]  op_result,
  input  logic                   sum_en,
  input  logic                   zero,
  output logic signed [wout-1:0] snd
);

  localparam logic signed [wout-1:0] PLUS_INF  = {1'b0, {(wout-1){1'b1}}};
  localparam logic signed [wout-1:0] MINUS_INF = {1'b1, {(wout-1){1'b0}}};

  logic signed [wout-1:0] acc_q, acc_d;
  logic signed [wout-1:0] snd_q;
  logic signed [wout-1:0] op_ext;
  logic signed [wout-1:0] current;
  logic signed [wout-1:0] next_val;
  logic                   overflow;

  generate
    if (win == wout) begin : g_noext
      assign op_ext = op_result;
    end else begin : g_ext
      assign op_ext = {{(wout-win){op_result[win-1]}}, op_result};
    end
  endgenerate

  always_comb begin
    current  = sum_en ? op_ext : '0;
    next_val = zero ? current : acc_q + current;
    // Same-sign operands whose wrapped sum flips sign; a zero cycle only seeds.
    overflow = !zero && (current[wout-1] == acc_q[wout-1])
                     && (next_val[wout-1] != acc_q[wout-1]);
    acc_d    = next_val;
    if (overflow) acc_d = acc_q[wout-1] ? MINUS_INF : PLUS_INF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      snd_q <= '0;
    end else if (clk_en) begin
      acc_q <= acc_d;
      if (zero) snd_q <= acc_q;
    end
  end

  assign snd = snd_q;

endmodule

// File: tb/tb_jt12_single_acc.sv
// Directed bench for jt12_single_acc: a 16/16 instance for arithmetic and gating,
// a 14/16 instance for sign extension and clamping of narrow inputs.
module tb_jt12_single_acc;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               clk_en = 1'b0;
  logic               sum_en = 1'b0;
  logic               zero = 1'b0;
  logic signed [15:0] op_a = '0;
  logic signed [13:0] op_b = '0;
  logic signed [15:0] snd_a;
  logic signed [15:0] snd_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  jt12_single_acc #(.win(16), .wout(16)) u_dut_a (
    .clk(clk), .rst(rst), .clk_en(clk_en), .op_result(op_a),
    .sum_en(sum_en), .zero(zero), .snd(snd_a)
  );

  jt12_single_acc #(.win(14), .wout(16)) u_dut_b (
    .clk(clk), .rst(rst), .clk_en(clk_en), .op_result(op_b),
    .sum_en(sum_en), .zero(zero), .snd(snd_b)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample #1 after the rising edge.
  task automatic step(input logic r, input logic ce, input logic se, input logic z,
                      input int a, input int b);
    rst    = r;
    clk_en = ce;
    sum_en = se;
    zero   = z;
    op_a   = a[15:0];
    op_b   = b[13:0];
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    // Reset with arbitrary inputs and clk_en low
    step(1, 0, 1, 1, 1234, 77);
    chk("reset_snd", int'(snd_a), 0);
    step(0, 1, 0, 1, 0, 0);
    chk("reset_empty_frame", int'(snd_a), 0);

    // Basic frame: seed 100, +200, -50, then zero with 7
    step(0, 1, 1, 1, 100, 0);
    chk("seed_publishes_old", int'(snd_a), 0);
    step(0, 1, 1, 0, 200, 0);
    step(0, 1, 1, 0, -50, 0);
    chk("snd_stable_midframe", int'(snd_a), 0);
    step(0, 1, 1, 1, 7, 0);
    chk("basic_sum", int'(snd_a), 250);
    step(0, 1, 0, 1, 0, 0);
    chk("seed_only_frame", int'(snd_a), 7);

    // Gating: sum_en low contributes nothing, clk_en low freezes everything
    step(0, 1, 0, 0, 1000, 0);
    step(0, 0, 1, 0, 500, 0);
    step(0, 0, 1, 1, 500, 0);
    chk("clk_en_hold_snd", int'(snd_a), 7);
    step(0, 1, 1, 0, 3, 0);
    step(0, 1, 0, 1, 0, 0);
    chk("gated_sum", int'(snd_a), 3);

    // Positive saturation
    step(0, 1, 1, 1, 32000, 0);
    chk("pos_seed", int'(snd_a), 0);
    step(0, 1, 1, 0, 1000, 0);
    step(0, 1, 1, 0, 1000, 0);
    step(0, 1, 0, 1, 0, 0);
    chk("pos_clamp", int'(snd_a), 32767);
    step(0, 1, 1, 1, 32000, 0);
    step(0, 1, 1, 0, 1000, 0);
    step(0, 1, 1, 0, 1000, 0);
    step(0, 1, 1, 0, -10, 0);
    step(0, 1, 1, 1, -32000, 0);
    chk("pos_clamp_then_sub", int'(snd_a), 32757);

    // Negative saturation, then a mixed-sign sum that must not clamp
    step(0, 1, 1, 0, -1000, 0);
    step(0, 1, 0, 1, 0, 0);
    chk("neg_clamp", int'(snd_a), -32768);
    step(0, 1, 1, 1, -32768, 0);
    chk("empty_after_neg", int'(snd_a), 0);
    step(0, 1, 1, 0, 32767, 0);
    step(0, 1, 0, 1, 0, 0);
    chk("mixed_sign", int'(snd_a), -1);

    // Back-to-back zero cycles
    step(0, 1, 1, 1, 42, 0);
    chk("b2b_first", int'(snd_a), 0);
    step(0, 1, 1, 1, 9, 0);
    chk("b2b_second", int'(snd_a), 42);
    step(0, 1, 0, 1, 0, 0);
    chk("b2b_third", int'(snd_a), 9);

    // Reset mid-frame discards the partial sum
    step(0, 1, 1, 0, 500, 0);
    step(1, 1, 1, 0, 500, 0);
    chk("midframe_reset", int'(snd_a), 0);
    step(0, 1, 0, 1, 0, 0);
    chk("after_reset_zero", int'(snd_a), 0);

    // Width extension on the 14-bit instance
    step(1, 0, 0, 0, 0, 0);
    chk("b_reset", int'(snd_b), 0);
    step(0, 1, 1, 1, 0, 'h2000);
    chk("b_seed", int'(snd_b), 0);
    step(0, 1, 1, 0, 0, 'h2000);
    step(0, 1, 1, 0, 0, 'h2000);
    step(0, 1, 1, 0, 0, 'h2000);
    step(0, 1, 0, 1, 0, 0);
    chk("b_neg_extend", int'(snd_b), -32768);
    step(0, 1, 1, 1, 0, 'h1FFF);
    step(0, 1, 1, 0, 0, 'h1FFF);
    step(0, 1, 1, 0, 0, 'h1FFF);
    step(0, 1, 1, 0, 0, 'h1FFF);
    step(0, 1, 1, 0, 0, 'h1FFF);
    step(0, 1, 0, 1, 0, 0);
    chk("b_pos_clamp", int'(snd_b), 32767);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
